multicore_memory_arbiter: RTL
=============================

# multicore_memory_arbiter

Parametrised, registered arbiter between CPUS processor cache ports (one instruction and one data port each) and the single shared RAM. It replaces the purely combinational single-core memory controller for the multicore pipeline. It adds a grant FSM, round-robin fairness across cores, data-over-instruction priority within a core, and request abort. It sits between the per-core caches and the RAM model.

## Interface
Parameters:
- CPUS, 2, number of cores; legal values are 1 to 8.
- ADDR_W, 32, address and data width (word_t).

Ports (array indices are per core):
- CLK  in  1  clock; everything is updated on the rising edge.
- nRST  in  1  reset; asynchronous, active-low.
- iREN[CPUS]  in  1  instruction read request.
- iaddr[CPUS]  in  ADDR_W  instruction address.
- dREN[CPUS] / dWEN[CPUS]  in  1  data read / write request. Asserting both is illegal; when both are set, dWEN wins.
- daddr[CPUS] / dstore[CPUS]  in  ADDR_W  data address / write data.
- iwait[CPUS] / dwait[CPUS]  out  1  held high until the port's access completes.
- iload[CPUS] / dload[CPUS]  out  ADDR_W  read data.
- ramaddr / ramstore  out  ADDR_W  RAM address / write data.
- ramREN / ramWEN  out  1  RAM read / write enable.
- ramload  in  ADDR_W  RAM read data.
- ramstate  in  ramstate_t  FREE / BUSY / ACCESS / ERROR.

## Operation
- The FSM has two states: IDLE and GRANT. Registered state: grant_cpu (index), grant_is_d (1 bit), grant_is_wr (1 bit), rr_ptr (index).
- IDLE:
  - A core is requesting if any of its iREN, dREN or dWEN is high.
  - The selected core is the first requesting core at or after rr_ptr, searching upward with wrap-around.
  - Within that core, a data request takes priority over an instruction request.
  - The choice is latched at the edge, and the FSM moves to GRANT.
  - If no core is requesting, the FSM stays in IDLE.
- GRANT:
  - ramaddr = the granted address. ramstore = dstore[grant_cpu] for writes, and 0 otherwise.
  - ramWEN = grant_is_wr. ramREN = !grant_is_wr.
  - When ramstate == ACCESS, the granted wait goes low in the same cycle (combinationally). For a read, the matching load = ramload.
  - At the next edge after ACCESS: FSM returns to IDLE, and rr_ptr = (grant_cpu+1) mod CPUS.
  - Abort: if the granted request line drops before ACCESS, the FSM returns to IDLE at the next edge. rr_ptr is unchanged, and ramREN/ramWEN are deasserted from that edge on.
  - ERROR behaves like BUSY: the FSM stays in GRANT and the wait stays high.
- All non-granted waits stay at 1, and all non-granted loads stay at 0.
- In IDLE: ramREN = ramWEN = 0, ramaddr = 0, ramstore = 0.

## Timing
- Reset values:
  - state = IDLE, rr_ptr = 0, grant fields = 0.
  - All iwait/dwait = 1, all loads = 0.
  - ramREN = ramWEN = 0, ramaddr = ramstore = 0.
- Reset asserted mid-GRANT: the transaction is dropped at once and the RAM enables fall asynchronously. After reset release, the requester must still be asserting and is re-arbitrated from core 0.
- Latency:
  - A request seen in IDLE at cycle N drives the RAM from cycle N+1.
  - The earliest completion is cycle N+1, when RAM returns ACCESS immediately.
  - Every transaction is followed by one IDLE cycle. Peak throughput is one access every 2 cycles.
- Simultaneous requests: only one is granted per IDLE cycle. The losers keep wait = 1 and must hold their request and address stable.
- Request inputs change while in GRANT: this does not alter the grant, except for the abort case.
- CPUS = 1: rr_ptr is always 0. Arbitration degenerates to D-over-I.

## Structure
- cpu_types_pkg holds word_t and ramstate_t, and gains arb_state_t (IDLE, GRANT) plus a width constant CPUID_W = $clog2(CPUS) (minimum 1).
- Sub-module rr_picker is a purely combinational round-robin selector over CPUS request bits starting at rr_ptr. It outputs valid and the selected index.
- All registers live in the top module. Outputs are muxed from the grant registers plus ramstate.

## Test plan
- Single-core instruction read: iREN[0]=1, iaddr=0x40, and RAM returns ACCESS on its 2nd GRANT cycle with ramload=0xDEADBEEF. Expect iwait[0] low for exactly that cycle, iload[0]=0xDEADBEEF, then one IDLE cycle.
- D-over-I on one core: iREN[1]=dWEN[1]=1, daddr=0x80, dstore=0x1234. Expect the first grant to be the write (ramWEN=1, ramaddr=0x80, ramstore=0x1234) and the instruction read to be granted after the IDLE cycle.
- Round-robin: both cores hold dREN continuously, with ACCESS after 1 cycle. Expect grants in the order 0,1,0,1 and dwait pulses alternating every 2 cycles.
- Abort: dREN[0] drops during GRANT while ramstate=BUSY. Expect ramREN=0 at the next edge, dwait[0] never low, and rr_ptr still 0.
- ERROR hold: ramstate=ERROR for 5 cycles, then ACCESS. Expect wait=1 throughout the ERROR cycles and the grant held; completion happens on the ACCESS cycle.
- Reset mid-grant: assert nRST=0 during GRANT. Expect ramREN/ramWEN=0 immediately and all waits=1; after release, core 0 is granted first.

Source files
------------

// File: rtl/cpu_types_pkg.sv
// Shared CPU/RAM types for the multicore memory path: word type, RAM handshake
// state, arbiter FSM state and the core-index width helper.
package cpu_types_pkg;
  localparam int WORD_W   = 32;
  localparam int CPUS_DEF = 2;

  typedef logic [WORD_W-1:0] word_t;

  typedef enum logic [1:0] {
    FREE   = 2'd0,
    BUSY   = 2'd1,
    ACCESS = 2'd2,
    ERROR  = 2'd3
  } ramstate_t;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } arb_state_t;

  // a single core still needs a 1-bit index
  function automatic int cpuid_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int CPUID_W = cpuid_w(CPUS_DEF);
endpackage

// File: rtl/rr_picker.sv
// Combinational round-robin selector: first set request bit at or after i_ptr,
// searching upward with wrap-around.
module rr_picker #(
  parameter int CPUS  = 2,
  parameter int IDX_W = 1
) (
  input  logic [CPUS-1:0]  i_req,
  input  logic [IDX_W-1:0] i_ptr,
  output logic             o_vld,
  output logic [IDX_W-1:0] o_idx
);
  logic [IDX_W-1:0] w_cand;

  // walk offsets from far to near so the nearest requester is the last write
  always_comb begin
    o_vld  = 1'b0;
    o_idx  = '0;
    w_cand = '0;
    for (int i = CPUS - 1; i >= 0; i--) begin
      w_cand = IDX_W'((int'(i_ptr) + i) % CPUS);
      if (i_req[w_cand]) begin
        o_vld = 1'b1;
        o_idx = w_cand;
      end
    end
  end
endmodule

// File: rtl/multicore_memory_arbiter.sv
// Registered round-robin arbiter between per-core I/D cache ports and one RAM.
// Data beats instruction within a core; a dropped request aborts the grant.
module multicore_memory_arbiter
  import cpu_types_pkg::*;
#(
  parameter int CPUS   = 2,
  parameter int ADDR_W = 32
) (
  input  logic                         CLK,
  input  logic                         nRST,
  input  logic [CPUS-1:0]              iREN,
  input  logic [CPUS-1:0][ADDR_W-1:0]  iaddr,
  input  logic [CPUS-1:0]              dREN,
  input  logic [CPUS-1:0]              dWEN,
  input  logic [CPUS-1:0][ADDR_W-1:0]  daddr,
  input  logic [CPUS-1:0][ADDR_W-1:0]  dstore,
  output logic [CPUS-1:0]              iwait,
  output logic [CPUS-1:0]              dwait,
  output logic [CPUS-1:0][ADDR_W-1:0]  iload,
  output logic [CPUS-1:0][ADDR_W-1:0]  dload,
  output logic [ADDR_W-1:0]            ramaddr,
  output logic [ADDR_W-1:0]            ramstore,
  output logic                         ramREN,
  output logic                         ramWEN,
  input  logic [ADDR_W-1:0]            ramload,
  input  ramstate_t                    ramstate
);
  localparam int IDX_W = cpuid_w(CPUS);

  arb_state_t       r_state;
  logic [IDX_W-1:0] r_grant_cpu;
  logic             r_grant_is_d;
  logic             r_grant_is_wr;
  logic [IDX_W-1:0] r_rr_ptr;

  logic [CPUS-1:0]  w_req;
  logic             w_sel_vld;
  logic [IDX_W-1:0] w_sel;
  logic             w_grant;
  logic             w_access;
  logic             w_live;
  logic [IDX_W-1:0] w_next_ptr;

  assign w_req = iREN | dREN | dWEN;

  rr_picker #(.CPUS(CPUS), .IDX_W(IDX_W)) u_pick (
    .i_req (w_req),
    .i_ptr (r_rr_ptr),
    .o_vld (w_sel_vld),
    .o_idx (w_sel)
  );

  assign w_grant  = (r_state == GRANT);
  assign w_access = w_grant && (ramstate == ACCESS);

  // the request line that must stay high for the grant to survive
  always_comb begin
    w_live = iREN[r_grant_cpu];
    if (r_grant_is_wr)     w_live = dWEN[r_grant_cpu];
    else if (r_grant_is_d) w_live = dREN[r_grant_cpu];
  end

  assign w_next_ptr = (r_grant_cpu == IDX_W'(CPUS - 1)) ? '0 : r_grant_cpu + 1'b1;

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_state       <= IDLE;
      r_grant_cpu   <= '0;
      r_grant_is_d  <= 1'b0;
      r_grant_is_wr <= 1'b0;
      r_rr_ptr      <= '0;
    end else if (r_state == IDLE) begin
      if (w_sel_vld) begin
        r_state       <= GRANT;
        r_grant_cpu   <= w_sel;
        r_grant_is_d  <= dREN[w_sel] | dWEN[w_sel];
        r_grant_is_wr <= dWEN[w_sel];
      end
    end else begin
      if (ramstate == ACCESS) begin
        r_state  <= IDLE;
        r_rr_ptr <= w_next_ptr;
      end else if (!w_live) begin
        r_state <= IDLE;
      end
    end
  end

  assign ramREN   = w_grant & ~r_grant_is_wr;
  assign ramWEN   = w_grant &  r_grant_is_wr;
  assign ramaddr  = !w_grant     ? '0 :
                    r_grant_is_d ? daddr[r_grant_cpu] : iaddr[r_grant_cpu];
  assign ramstore = (w_grant && r_grant_is_wr) ? dstore[r_grant_cpu] : '0;

  for (genvar c = 0; c < CPUS; c++) begin : g_core
    logic w_hit;
    assign w_hit    = w_access && (r_grant_cpu == IDX_W'(c));
    assign iwait[c] = ~(w_hit && !r_grant_is_d);
    assign dwait[c] = ~(w_hit &&  r_grant_is_d);
    assign iload[c] = (w_hit && !r_grant_is_d) ? ramload : '0;
    assign dload[c] = (w_hit && r_grant_is_d && !r_grant_is_wr) ? ramload : '0;
  end
endmodule
